// File: rtl/elevator_pkg.sv
// Shared constants for the elevator car sequencer.
//   NUM_FLOORS / FLOOR_W / TOP_FLOOR : building geometry (8 floors, 3-bit index)
//   DIR_UP / DIR_DOWN                : travel direction encoding
//   IDLE / MOVE / ARRIVE / DOOR      : sequencer state encoding
//   next_floor()                     : one-floor step in a given direction
package elevator_pkg;

   localparam int unsigned NUM_FLOORS = 8;
   localparam int unsigned FLOOR_W    = 3;
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = 3'd7;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t MOVE   = 2'd1;
   localparam state_t ARRIVE = 2'd2;
   localparam state_t DOOR   = 2'd3;

   // 3-bit step; callers guarantee no step is taken past either end stop.
   function automatic logic [FLOOR_W-1:0] next_floor(input logic [FLOOR_W-1:0] f,
                                                     input logic dir);
      return (dir == DIR_UP) ? f + 3'd1 : f - 3'd1;
   endfunction

endpackage

// File: rtl/car_motion_sequencer_if.sv
// Bundle between the elevator controller and the car motion sequencer.
//   master : controller side, drives requests/calls/door_hold, observes car status
//   slave  : sequencer side, consumes requests, reports floor/motion/door status
interface car_motion_sequencer_if;
   import elevator_pkg::*;

   logic                  should_move;
   logic                  direction;
   logic [NUM_FLOORS-1:0] call_inside;
   logic [NUM_FLOORS-1:0] call_up;
   logic [NUM_FLOORS-1:0] call_down;
   logic                  door_hold;
   logic [FLOOR_W-1:0]    cur_floor;
   logic                  floor_reached;
   logic                  moving;
   logic                  door_open;
   logic                  travel_dir;

   modport master (
      output should_move, direction, call_inside, call_up, call_down, door_hold,
      input  cur_floor, floor_reached, moving, door_open, travel_dir
   );

   modport slave (
      input  should_move, direction, call_inside, call_up, call_down, door_hold,
      output cur_floor, floor_reached, moving, door_open, travel_dir
   );

endinterface

// File: rtl/timer_count.sv
// Loadable down-counter with a zero flag.
//   clk, reset : clock and synchronous active-high reset (count cleared to 0)
//   load       : load load_val on the next edge (wins over en)
//   en         : decrement by one per edge, saturating at 0
//   zero       : count is currently 0
module timer_count #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/car_motion_sequencer.sv
// Motion and door sequencer for the elevator car.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of car_motion_sequencer_if
//                in : should_move, direction, call_inside/up/down, door_hold
//                out: cur_floor, floor_reached (ARRIVE pulse), moving, door_open,
//                     travel_dir
// All outputs are registered or decoded from state only.
module car_motion_sequencer
   import elevator_pkg::*;
#(
   parameter int unsigned TRAVEL_CYCLES = 16,
   parameter int unsigned DOOR_CYCLES   = 32,
   parameter int unsigned RESET_FLOOR   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   car_motion_sequencer_if.slave bus
);

   localparam int unsigned TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX);

   state_t             state_q, state_d;
   logic [FLOOR_W-1:0] floor_q, floor_d;
   logic               dir_q, dir_d;

   logic travel_load, travel_en, travel_zero;
   logic door_load, door_en, door_zero;

   logic [FLOOR_W-1:0] nf;
   logic               here_call, stop_at_nf, door_call, blocked;

   timer_count #(.WIDTH(TW)) u_travel_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (travel_load),
      .load_val (TW'(TRAVEL_CYCLES - 1)),
      .en       (travel_en),
      .zero     (travel_zero)
   );

   timer_count #(.WIDTH(TW)) u_door_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (door_load),
      .load_val (TW'(DOOR_CYCLES - 1)),
      .en       (door_en),
      .zero     (door_zero)
   );

   always_comb begin
      nf         = next_floor(floor_q, dir_q);
      here_call  = bus.call_inside[floor_q] | bus.call_up[floor_q] | bus.call_down[floor_q];
      // Opposite-direction hall calls do not stop a passing car.
      stop_at_nf = bus.call_inside[nf]
                 | ((dir_q == DIR_UP)   && bus.call_up[nf])
                 | ((dir_q == DIR_DOWN) && bus.call_down[nf])
                 | ((dir_q == DIR_UP)   && (nf == TOP_FLOOR))
                 | ((dir_q == DIR_DOWN) && (nf == '0));
      door_call  = bus.call_inside[floor_q]
                 | ((dir_q == DIR_UP)   && bus.call_up[floor_q])
                 | ((dir_q == DIR_DOWN) && bus.call_down[floor_q]);
      blocked    = ((bus.direction == DIR_UP)   && (floor_q == TOP_FLOOR))
                 | ((bus.direction == DIR_DOWN) && (floor_q == '0));
   end

   always_comb begin
      state_d     = state_q;
      floor_d     = floor_q;
      dir_d       = dir_q;
      travel_load = 1'b0;
      travel_en   = 1'b0;
      door_load   = 1'b0;
      door_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (here_call) begin
               state_d = ARRIVE;
            end else if (bus.should_move && !blocked) begin
               state_d     = MOVE;
               dir_d       = bus.direction;
               travel_load = 1'b1;
            end
         end
         MOVE: begin
            if (travel_zero) begin
               floor_d = nf;
               if (stop_at_nf) begin
                  state_d = ARRIVE;
               end else begin
                  travel_load = 1'b1;
               end
            end else begin
               travel_en = 1'b1;
            end
         end
         ARRIVE: begin
            door_load = 1'b1;
            state_d   = DOOR;
         end
         DOOR: begin
            if (door_call) begin
               // Re-arrive so the new call is cleared; ARRIVE reloads the timer.
               state_d   = ARRIVE;
               door_load = 1'b1;
            end else if (bus.door_hold) begin
               door_load = 1'b1;
            end else if (door_zero) begin
               state_d = IDLE;
            end else begin
               door_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         floor_q <= FLOOR_W'(RESET_FLOOR);
         dir_q   <= DIR_UP;
      end else begin
         state_q <= state_d;
         floor_q <= floor_d;
         dir_q   <= dir_d;
      end
   end

   assign bus.cur_floor     = floor_q;
   assign bus.travel_dir    = dir_q;
   assign bus.moving        = (state_q == MOVE);
   assign bus.door_open     = (state_q == DOOR);
   assign bus.floor_reached = (state_q == ARRIVE);

endmodule

// File: doc/car_motion_sequencer.md
# car_motion_sequencer

Cycle-level motion and door sequencer for the elevator car. It consumes `should_move`/`direction` and the three call vectors from `controller`, then steps the car one floor per travel interval. It decides where to stop, pulses `floor_reached` so the stopped floor's requests are cleared, and times the door. Its `cur_floor` output drives `controller.cur_floor_in`; its `floor_reached` drives `controller.floor_reached`.

## Interface
Parameters:
- `TRAVEL_CYCLES`, default 16: clock cycles spent travelling between adjacent floors (≥2).
- `DOOR_CYCLES`, default 32: clock cycles the door stays open (≥2).
- `RESET_FLOOR`, default 0: floor loaded on reset (0..7).

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `should_move`  in  1  a request exists away from the current floor.
- `direction`  in  1  requested travel direction, 1 = up, 0 = down.
- `call_inside`  in  8  per-floor in-car requests.
- `call_up`  in  8  per-floor hall up requests.
- `call_down`  in  8  per-floor hall down requests.
- `door_hold`  in  1  door-open button; while in DOOR, restarts the door timer.
- `cur_floor`  out  3  current car floor.
- `floor_reached`  out  1  one-cycle pulse: car stopped at `cur_floor`, clear its requests.
- `moving`  out  1  high in MOVE.
- `door_open`  out  1  high in DOOR.
- `travel_dir`  out  1  latched direction of the current or last trip.

## Operation
States:
- **IDLE**: car stationary, door closed.
- **MOVE**: car travelling.
- **ARRIVE**: single-cycle stop.
- **DOOR**: door open for `DOOR_CYCLES`.

Transitions:
- **IDLE, call at current floor**: a call at the current floor is `call_inside[f] | call_up[f] | call_down[f]` for f = `cur_floor`. If set, go to ARRIVE. This has priority over `should_move`.
- **IDLE, move request**: else if `should_move`, and not (`direction`=1 and f=7), and not (`direction`=0 and f=0), go to MOVE. Latch `travel_dir <= direction` and load the travel timer with `TRAVEL_CYCLES-1`.
- **IDLE, blocked or no request**: a blocked end-stop request or no request leaves the car in IDLE; no error is flagged.
- **MOVE**: the timer decrements each cycle. When it reaches 0, the next floor is nf = `cur_floor` ± 1 according to `travel_dir`, and `cur_floor <= nf` on that edge.
  - The stop decision uses nf on the same edge.
  - Stop if `call_inside[nf]`, or `call_up[nf]` when `travel_dir`=1, or `call_down[nf]` when `travel_dir`=0, or nf is 7 going up or 0 going down.
  - Stop goes to ARRIVE. Otherwise stay in MOVE and reload the timer.
  - Opposite-direction hall calls are passed.
- **ARRIVE**: `floor_reached`=1 for exactly this cycle. Load the door timer with `DOOR_CYCLES-1` and go to DOOR.
- **DOOR**: the timer decrements each cycle.
  - If `door_hold` is high, or a new call at `cur_floor` matches `travel_dir` or is an inside call, reload the timer. A new call also re-enters ARRIVE, pulsing `floor_reached` again.
  - When the timer reaches 0 with no hold, go to IDLE.
- **Width rules**: floor arithmetic is 3-bit. Wrap-around is impossible because the end-stop rules above forbid it. Timer width is `$clog2(max(TRAVEL_CYCLES, DOOR_CYCLES))`.

## Timing
- **Reset**: takes effect on the edge where `reset`=1, regardless of state, including mid-MOVE and mid-DOOR.
  - Sets state=IDLE, `cur_floor`=`RESET_FLOOR`, `travel_dir`=1, and both timers to 0.
  - All outputs read as follows: `moving`=0, `door_open`=0, `floor_reached`=0.
- **Output decode**: all outputs are registered or decoded directly from state (Moore). There is no combinational path from inputs to outputs.
- **IDLE→MOVE**: one cycle after `should_move` is sampled.
- **First floor step**: `cur_floor` changes `TRAVEL_CYCLES` cycles after MOVE entry, then every `TRAVEL_CYCLES` cycles.
- **Stop sequence**: ARRIVE occupies the cycle after the final floor step. DOOR lasts exactly `DOOR_CYCLES` cycles without a hold, then returns to IDLE.
- **Call into an idle car at its floor**: ARRIVE is entered on the next edge.
- **Input stability**: call vectors may change in any cycle and are sampled only on the decision edges listed above.

## Structure
- **Package `elevator_pkg`**: holds the state enum (`IDLE`, `MOVE`, `ARRIVE`, `DOOR`), `NUM_FLOORS`=8, `FLOOR_W`=3, `TOP_FLOOR`=7, and `DIR_UP`/`DIR_DOWN` constants.
- **Sub-module `timer_count`**: a loadable down-counter with `load`, `load_val`, `en` and a `zero` flag. Instantiate it twice, once for travel and once for the door.
- **FSM and stop logic**: remain in this module.

## Test plan
All scenarios use `TRAVEL_CYCLES`=4, `DOOR_CYCLES`=6 and `RESET_FLOOR`=0.
- Reset held 2 cycles → `cur_floor`=0, `moving`=0, `door_open`=0, `floor_reached`=0, `travel_dir`=1.
- From floor 0, `call_inside[3]`=1, `should_move`=1, `direction`=1 → `cur_floor` steps 1,2,3 at cycles 4,8,12 after MOVE entry. Then `floor_reached` pulses once at floor 3, `door_open` is high for 6 cycles, then IDLE.
- Moving up from 0 with `call_down[2]`=1 and `call_inside[5]`=1 → no stop at 2. Stop at 5 with a single `floor_reached` pulse.
- At floor 7, `should_move`=1 with `direction`=1 → remains IDLE indefinitely. Moving up from 5 with a spurious call only at 7 still stops at 7.
- In DOOR at floor 3, `door_hold` pulsed on door cycle 4 → `door_open` stays high for 4+6 cycles total. `call_inside[3]` raised during DOOR → a second `floor_reached` pulse.
- `reset` asserted while in MOVE at `cur_floor`=4 → the next cycle shows `cur_floor`=0, IDLE, `moving`=0, and no `floor_reached`.
